// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned ADDR_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Per-transaction attributes kept from acceptance until the response.
  typedef struct packed {
    logic is_write;
    logic oob;
  } req_tag_t;

  // 33-bit offset so addresses below base wrap to a huge value and miss.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       depth);
    logic [ADDR_W:0] offset;
    logic [ADDR_W:0] limit;
    offset = {1'b0, addr} - {1'b0, base};
    limit  = (33'(depth)) << 2;
    return offset < limit;
  endfunction

endpackage

// File: rtl/dmem_sram_1p.sv
// Single-port SRAM with per-lane write enables and a registered read port.
module dmem_sram_1p #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned LANE_W = DATA_W / LANES;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data only updates on read accesses, so it holds until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-outstanding request, programmable wait
// states, one-cycle response pulse, sticky out-of-range and overlap flags.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_dmemReq_valid,
  input  logic [ADDR_W-1:0] io_dmemReq_bits_addrRequest,
  input  logic [DATA_W-1:0] io_dmemReq_bits_dataRequest,
  input  logic [LANES-1:0]  io_dmemReq_bits_activeByteLane,
  input  logic              io_dmemReq_bits_isWrite,
  output logic              io_dmemRsp_valid,
  output logic [DATA_W-1:0] io_dmemRsp_bits_dataResponse,
  output logic              err_oob,
  output logic              err_overlap
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  req_tag_t              tag;
  logic                  rd_ok;
  logic [DATA_W-1:0]     sram_rdata;

  logic                  hit_c;
  logic                  accept_c;
  logic [ADDR_W-1:0]     offset_c;
  logic [IDX_W-1:0]      idx_c;

  assign hit_c    = in_range(io_dmemReq_bits_addrRequest, BASE_ADDR, DEPTH_WORDS);
  assign accept_c = (state == S_IDLE) && io_dmemReq_valid;
  assign offset_c = io_dmemReq_bits_addrRequest - BASE_ADDR;
  assign idx_c    = IDX_W'(offset_c >> 2);

  // The array is accessed on the acceptance edge; out-of-range requests never touch it.
  dmem_sram_1p #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .AW     (IDX_W)
  ) u_sram (
    .clk   (clock),
    .en    (accept_c && hit_c),
    .we    (io_dmemReq_bits_isWrite),
    .be    (io_dmemReq_bits_activeByteLane),
    .addr  (idx_c),
    .wdata (io_dmemReq_bits_dataRequest),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      tag              <= '0;
      rd_ok            <= 1'b0;
      io_dmemRsp_valid <= 1'b0;
      err_oob          <= 1'b0;
      err_overlap      <= 1'b0;
    end else begin
      io_dmemRsp_valid <= 1'b0;
      rd_ok            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io_dmemReq_valid) begin
            tag <= '{is_write: io_dmemReq_bits_isWrite, oob: !hit_c};
            if (!hit_c) err_oob <= 1'b1;
            if (WAIT_STATES == 0) begin
              state            <= S_RESP;
              io_dmemRsp_valid <= 1'b1;
              rd_ok            <= !io_dmemReq_bits_isWrite && hit_c;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (io_dmemReq_valid) err_overlap <= 1'b1;
          if (wait_cnt == '0) begin
            state            <= S_RESP;
            io_dmemRsp_valid <= 1'b1;
            rd_ok            <= !tag.is_write && !tag.oob;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (io_dmemReq_valid) err_overlap <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data is only driven during the response of an in-range read.
  assign io_dmemRsp_bits_dataResponse = rd_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three builds (1, 0 and 3 wait states).
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  lanes;
  logic        wr;
  logic [2:0]  v;

  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        oob [3];
  logic        ovl [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clock(clock), .reset(reset),
    .io_dmemReq_valid(v[0]), .io_dmemReq_bits_addrRequest(addr),
    .io_dmemReq_bits_dataRequest(wdata), .io_dmemReq_bits_activeByteLane(lanes),
    .io_dmemReq_bits_isWrite(wr), .io_dmemRsp_valid(rv[0]),
    .io_dmemRsp_bits_dataResponse(rd[0]), .err_oob(oob[0]), .err_overlap(ovl[0]));

  dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut1 (
    .clock(clock), .reset(reset),
    .io_dmemReq_valid(v[1]), .io_dmemReq_bits_addrRequest(addr),
    .io_dmemReq_bits_dataRequest(wdata), .io_dmemReq_bits_activeByteLane(lanes),
    .io_dmemReq_bits_isWrite(wr), .io_dmemRsp_valid(rv[1]),
    .io_dmemRsp_bits_dataResponse(rd[1]), .err_oob(oob[1]), .err_overlap(ovl[1]));

  dmem_ctrl #(.DEPTH_WORDS(4), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut2 (
    .clock(clock), .reset(reset),
    .io_dmemReq_valid(v[2]), .io_dmemReq_bits_addrRequest(addr),
    .io_dmemReq_bits_dataRequest(wdata), .io_dmemReq_bits_activeByteLane(lanes),
    .io_dmemReq_bits_isWrite(wr), .io_dmemRsp_valid(rv[2]),
    .io_dmemRsp_bits_dataResponse(rd[2]), .err_oob(oob[2]), .err_overlap(ovl[2]));

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest pending entry for that build.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
          if (sbq[i].id == k) begin
            idx = i;
            break;
          end
        end
        if (idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_rsp dut%0d: got rsp_valid=1 at cycle %0d expected no response", k, cyc);
        end else begin
          chk($sformatf("rsp_cycle dut%0d", k), 64'(cyc), 64'(sbq[idx].cyc));
          chk($sformatf("rsp_data dut%0d", k), 64'(rd[k]), 64'(sbq[idx].data));
          sbq.delete(idx);
        end
      end
    end
  end

  // Accept edge is the next posedge; then wait until the build is idle again.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic w, input logic [31:0] exp);
    @(negedge clock);
    addr = a; wdata = d; lanes = be; wr = w;
    v = '0; v[k] = 1'b1;
    sbq.push_back('{k, cyc + 1 + ws_of(k), exp});
    @(posedge clock);
    #1 v = '0;
    repeat (ws_of(k) + 1) @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; lanes = '0; wr = 1'b0; v = '0;
    repeat (3) @(negedge clock);
    chk("reset_outputs dut0", {29'd0, rv[0], oob[0], ovl[0], rd[0]}, 64'd0);
    reset = 1'b1;

    // Idle after reset: no activity on any output.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      for (int k = 0; k < 3; k++)
        chk($sformatf("idle_outputs dut%0d c%0d", k, c), {29'd0, rv[k], oob[k], ovl[k], rd[k]}, 64'd0);
    end

    // Build 0 (1 wait state): write, read back, partial lanes, empty lanes.
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
    issue(0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    issue(0, 32'h20, 32'h11223344, 4'hF, 1'b1, 32'h0);
    issue(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h0);
    issue(0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);
    issue(0, 32'h10, 32'h55555555, 4'h0, 1'b1, 32'h0);
    issue(0, 32'h13, 32'h0, 4'h1, 1'b0, 32'hDEADBEEF);

    // Out of range must not alias word 0.
    issue(0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0);
    chk("oob_clear dut0", 64'(oob[0]), 64'd0);
    issue(0, 32'h1000, 32'h12345678, 4'hF, 1'b1, 32'h0);
    chk("oob_set dut0", 64'(oob[0]), 64'd1);
    issue(0, 32'h1000, 32'h0, 4'hF, 1'b0, 32'h0);
    issue(0, 32'h0, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);

    // Overlap: valid held through the busy cycles; only one response.
    chk("overlap_clear dut0", 64'(ovl[0]), 64'd0);
    @(negedge clock);
    addr = 32'h20; wr = 1'b0; lanes = 4'hF; v = 3'b001;
    sbq.push_back('{0, cyc + 2, 32'h11BB33DD});
    repeat (3) @(posedge clock);
    #1 v = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("overlap_set dut0", 64'(ovl[0]), 64'd1);
    chk("overlap_no_oob_change dut0", 64'(oob[0]), 64'd1);

    // Reset during WAIT aborts the response but keeps the committed write.
    @(negedge clock);
    addr = 32'h30; wdata = 32'h55AA55AA; lanes = 4'hF; wr = 1'b1; v = 3'b001;
    @(posedge clock);
    #1 v = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("post_reset_errs dut0", {62'd0, oob[0], ovl[0]}, 64'd0);
    repeat (3) @(posedge clock);
    issue(0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h55AA55AA);
    issue(0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);

    // Build 1 (no wait states, 16 words).
    issue(1, 32'h4, 32'h0BADCAFE, 4'hF, 1'b1, 32'h0);
    issue(1, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0BADCAFE);
    chk("oob_clear dut1", 64'(oob[1]), 64'd0);
    issue(1, 32'h40, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("oob_set dut1", 64'(oob[1]), 64'd1);

    // Build 2 (3 wait states, 4 words at 0x1000).
    issue(2, 32'h100C, 32'h77665544, 4'hF, 1'b1, 32'h0);
    issue(2, 32'h100C, 32'h0, 4'hF, 1'b0, 32'h77665544);
    chk("oob_clear dut2", 64'(oob[2]), 64'd0);
    issue(2, 32'h0FFC, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("oob_below_base dut2", 64'(oob[2]), 64'd1);
    issue(2, 32'h1010, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("overlap_clear dut2", 64'(ovl[2]), 64'd0);

    repeat (10) @(posedge clock);
    while (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_rsp dut%0d: got no response expected one at cycle %0d", sbq[0].id, sbq[0].cyc);
      void'(sbq.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
